// File: rtl/reg_file_pkg.sv
// Shared types and helpers for reg_file_mp: FSM state enum, byte-count helper,
// and the byte-enable merge used by both the write path and the read bypass.
package reg_file_pkg;

   typedef enum logic [0:0] {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } rf_state_e;

   // merge_be works on a fixed wide bus; callers size-cast in and out.
   localparam int unsigned MAX_DW = 256;
   localparam int unsigned MAX_BE = MAX_DW / 8;

   function automatic int unsigned be_count(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic logic [MAX_DW-1:0] merge_be(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_BE-1:0] be
   );
      logic [MAX_DW-1:0] m;
      m = old_w;
      for (int k = 0; k < int'(MAX_BE); k++) begin
         if (be[k]) m[8*k +: 8] = new_w[8*k +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port of reg_file_mp: combinational or registered read, write-first bypass,
// valid tracking and (with REG_FILE_MP_PARITY_EN) a parity-error flag.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int RD_LATENCY = 0
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_ready,
   input  logic                            i_r_en,
   input  logic [ADDR_WIDTH-1:0]           i_r_addr,
   input  logic [DATA_WIDTH-1:0]           i_mem_word,
   input  logic                            i_w_en,
   input  logic [ADDR_WIDTH-1:0]           i_w_addr,
   input  logic [DATA_WIDTH-1:0]           i_w_data,
   input  logic [be_count(DATA_WIDTH)-1:0] i_w_be,
`ifdef REG_FILE_MP_PARITY_EN
   input  logic                            i_mem_par,
   output logic                            o_r_parity_err,
`endif
   output logic [DATA_WIDTH-1:0]           o_r_data,
   output logic                            o_r_valid
);

   logic                  rd_fire;
   logic                  hit;
   logic [DATA_WIDTH-1:0] byp_word;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;

   assign rd_fire  = i_ready & i_r_en;
   assign hit      = i_ready & i_w_en & (i_w_addr == i_r_addr);
   assign byp_word = hit ? DATA_WIDTH'(merge_be(MAX_DW'(i_mem_word), MAX_DW'(i_w_data), MAX_BE'(i_w_be)))
                         : i_mem_word;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= rd_fire;
         if (rd_fire) data_q <= byp_word;
      end
   end

   // Latency 0 sees the stored word only, so same-cycle writes read old data.
   assign o_r_data  = (RD_LATENCY == 0) ? (i_ready ? i_mem_word : '0) : data_q;
   assign o_r_valid = (RD_LATENCY == 0) ? rd_fire : valid_q;

`ifdef REG_FILE_MP_PARITY_EN
   logic par_bad;
   logic err_q;

   assign par_bad = (^i_mem_word) ^ i_mem_par;

   // A bypassed word carries freshly computed parity, so it can never be in error.
   always_ff @(posedge i_clk) begin
      if (i_rst) err_q <= 1'b0;
      else       err_q <= rd_fire & ~hit & par_bad;
   end

   assign o_r_parity_err = (RD_LATENCY == 0) ? (rd_fire & par_bad) : err_q;
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-enable writes and a post-reset init sweep.
// Define REG_FILE_MP_PARITY_EN to store an even-parity bit per entry and expose o_r_parity_err.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    NUM_RD     = 2,
   parameter int                    RD_LATENCY = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_w_en,
   input  logic [ADDR_WIDTH-1:0]           i_w_addr,
   input  logic [DATA_WIDTH-1:0]           i_w_data,
   input  logic [be_count(DATA_WIDTH)-1:0] i_w_be,
   input  logic [NUM_RD-1:0]               i_r_en,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]    i_r_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]    o_r_data,
   output logic [NUM_RD-1:0]               o_r_valid,
`ifdef REG_FILE_MP_PARITY_EN
   output logic [NUM_RD-1:0]               o_r_parity_err,
`endif
   output logic                            o_init_busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef REG_FILE_MP_PARITY_EN
   localparam int MEM_W = DATA_WIDTH + 1;
`else
   localparam int MEM_W = DATA_WIDTH;
`endif

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic [MEM_W-1:0]      mem_q [DEPTH];
   logic                  ready;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [MEM_W-1:0]      wr_word;

   assign ready       = (state_q == ST_READY);
   assign o_init_busy = ~ready;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
         if (&init_cnt_q) state_d = ST_READY;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // The init sweep owns the write port until ready; user writes are dropped meanwhile.
   assign wr_en   = ~i_rst & (~ready | i_w_en);
   assign wr_addr = ready ? i_w_addr : init_cnt_q;
   assign wr_data = ready ? DATA_WIDTH'(merge_be(MAX_DW'(mem_q[i_w_addr][DATA_WIDTH-1:0]),
                                                 MAX_DW'(i_w_data), MAX_BE'(i_w_be)))
                          : INIT_VALUE;

`ifdef REG_FILE_MP_PARITY_EN
   assign wr_word = {^wr_data, wr_data};
`else
   assign wr_word = wr_data;
`endif

   always_ff @(posedge i_clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_word;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [MEM_W-1:0] word;
         assign word = mem_q[i_r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]];

         reg_file_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .RD_LATENCY (RD_LATENCY)
         ) u_port (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_ready        (ready),
            .i_r_en         (i_r_en[gi]),
            .i_r_addr       (i_r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_mem_word     (word[DATA_WIDTH-1:0]),
            .i_w_en         (i_w_en),
            .i_w_addr       (i_w_addr),
            .i_w_data       (i_w_data),
            .i_w_be         (i_w_be),
`ifdef REG_FILE_MP_PARITY_EN
            .i_mem_par      (word[DATA_WIDTH]),
            .o_r_parity_err (o_r_parity_err[gi]),
`endif
            .o_r_data       (o_r_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .o_r_valid      (o_r_valid[gi])
         );
      end
   endgenerate

endmodule
